// File: rtl/instr_encoder_if.sv
// instr_encoder_if: job request and encoded-instruction response bundle for instr_encoder.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: RV32 I/S/B/U/J instruction encoder feeding a 2-entry output FIFO.
// Define INSTR_ENCODER_RANGE_CHECK_EN to flag immediates the format cannot represent.
module instr_encoder #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    instr_encoder_if.slave     bus,
    output logic [COUNT_W-1:0] enc_count
);
    logic [31:0]        w_instr;
    logic               w_bad;
    logic               w_err;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_cnt_nxt;
    logic [31:0]        r_instr [2];
    logic [1:0]         r_err;
    logic               r_wp;
    logic               r_rp;
    logic [1:0]         r_cnt;
    logic               r_in_ready;
    logic [COUNT_W-1:0] r_enc_count;

    always_comb begin
        w_instr = '0;
        case (bus.fmt)
            3'd0: w_instr = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            3'd1: w_instr = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
            3'd2: w_instr = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                             bus.imm[4:1], bus.imm[11], bus.opcode};
            3'd3: w_instr = {bus.imm[31:12], bus.rd, bus.opcode};
            3'd4: w_instr = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
            default: w_instr = '0;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    // A value fits when every bit above the field's sign bit copies that sign bit.
    always_comb begin
        w_bad = 1'b0;
        case (bus.fmt)
            3'd0, 3'd1: w_bad = bus.imm[31:11] != {21{bus.imm[11]}};
            3'd2:       w_bad = bus.imm[0] || (bus.imm[31:12] != {20{bus.imm[12]}});
            3'd3:       w_bad = bus.imm[11:0] != 12'd0;
            3'd4:       w_bad = bus.imm[0] || (bus.imm[31:20] != {12{bus.imm[20]}});
            default:    w_bad = 1'b0;
        endcase
    end
`else
    assign w_bad = 1'b0;
`endif

    assign w_err     = (bus.fmt > 3'd4) || w_bad;
    assign w_push    = bus.in_valid && r_in_ready;
    assign w_pop     = (r_cnt != 2'd0) && bus.out_ready;
    assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr[0]  <= '0;
            r_instr[1]  <= '0;
            r_err       <= '0;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_enc_count <= '0;
        end else begin
            if (w_push) begin
                r_instr[r_wp] <= w_err ? 32'd0 : w_instr;
                r_err[r_wp]   <= w_err;
                r_wp          <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
                if (!r_err[r_rp])
                    r_enc_count <= r_enc_count + COUNT_W'(1);
            end
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= w_cnt_nxt != 2'd2;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_cnt != 2'd0;
    assign bus.out_instr = (r_cnt != 2'd0) ? r_instr[r_rp] : 32'd0;
    assign bus.out_err   = (r_cnt != 2'd0) && r_err[r_rp];
    assign enc_count     = r_enc_count;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a queue-based model.
module tb_instr_encoder;
    typedef struct {
        logic [2:0]  f;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
    } job_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] enc_count;
    instr_encoder_if bus();

    instr_encoder #(.COUNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .enc_count (enc_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [32:0] m_q[$];
    logic [15:0] m_cnt = 0;
    bit          m_rdy = 0;

    function automatic job_t mk(int f, int op, int rd, int rs1, int rs2, int f3, int imm);
        job_t j;
        j.f = 3'(f); j.op = 7'(op); j.rd = 5'(rd); j.rs1 = 5'(rs1);
        j.rs2 = 5'(rs2); j.f3 = 3'(f3); j.imm = 32'(imm);
        return j;
    endfunction

    // Reference encoding built from shifts and masks of the field layouts; {err, instr}.
    function automatic logic [32:0] ref_enc(job_t j);
        logic [31:0] x = j.imm;
        int          s = $signed(j.imm);
        logic [31:0] r = 0;
        bit          e = j.f > 4;
        logic [31:0] regs = (32'(j.rs2) << 20) | (32'(j.rs1) << 15) | (32'(j.f3) << 12);
        case (j.f)
            0: r = ((x & 32'hFFF) << 20) | (32'(j.rs1) << 15) | (32'(j.f3) << 12) | (32'(j.rd) << 7);
            1: r = (((x >> 5) & 32'h7F) << 25) | regs | ((x & 32'h1F) << 7);
            2: r = (((x >> 12) & 1) << 31) | (((x >> 5) & 32'h3F) << 25) | regs
                 | (((x >> 1) & 32'hF) << 8) | (((x >> 11) & 1) << 7);
            3: r = (x & 32'hFFFF_F000) | (32'(j.rd) << 7);
            4: r = (((x >> 20) & 1) << 31) | (((x >> 1) & 32'h3FF) << 21) | (((x >> 11) & 1) << 20)
                 | (((x >> 12) & 32'hFF) << 12) | (32'(j.rd) << 7);
            default: r = 0;
        endcase
        r = r | 32'(j.op);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        case (j.f)
            0, 1: e = s < -2048 || s > 2047;
            2: e = (s % 2 != 0) || s < -4096 || s > 4094;
            3: e = (x & 32'hFFF) != 0;
            4: e = (s % 2 != 0) || s < -1048576 || s > 1048574;
            default: e = 1;
        endcase
`else
        if (s == 0) e = e;
`endif
        return e ? 33'h1_0000_0000 : {1'b0, r};
    endfunction

    function automatic job_t rand_job();
        int bnd[16] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                        1048574, 1048575, -1048576, -1048578, 1048576, 0, 4096, -4097};
        job_t j;
        j.f = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        j.op = 7'($urandom); j.rd = 5'($urandom); j.rs1 = 5'($urandom);
        j.rs2 = 5'($urandom); j.f3 = 3'($urandom);
        case ($urandom_range(0, 3))
            0: j.imm = $urandom;
            1: j.imm = 32'($signed($urandom_range(0, 10000)) - 5000);
            2: j.imm = 32'(bnd[$urandom_range(0, 15)]);
            default: j.imm = $urandom & 32'hFFFF_F000;
        endcase
        return j;
    endfunction

    // Drives one cycle of inputs, advances the model across the coming edge, waits to the next negedge.
    task automatic drive(input bit v, input job_t j, input bit ordy);
        bit          push;
        bit          pop;
        logic [32:0] tmp;
        bus.in_valid = v; bus.fmt = j.f; bus.opcode = j.op; bus.rd = j.rd;
        bus.rs1 = j.rs1; bus.rs2 = j.rs2; bus.funct3 = j.f3; bus.imm = j.imm;
        bus.out_ready = ordy;
        push = v && m_rdy;
        pop = (m_q.size() != 0) && ordy;
        if (pop) begin
            tmp = m_q.pop_front();
            if (!tmp[32]) m_cnt++;
        end
        if (push) m_q.push_back(ref_enc(j));
        m_rdy = m_q.size() < 2;
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.in_valid = 0; bus.out_ready = 0;
        rst = 1;
        m_q.delete(); m_cnt = 0; m_rdy = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        m_rdy = 1;
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.out_ready = 1; bus.fmt = 0; bus.opcode = 0; bus.rd = 0;
        bus.rs1 = 0; bus.rs2 = 0; bus.funct3 = 0; bus.imm = 0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_err, bus.out_instr, bus.in_ready, enc_count} !== 51'd0) begin
            failures++;
            $display("FAIL reset_state: valid=%b err=%b instr=%h in_ready=%b cnt=%0d, required all 0",
                     bus.out_valid, bus.out_err, bus.out_instr, bus.in_ready, enc_count);
        end
        rst = 0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge: in_ready=%b required 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_edge: in_ready=%b required 1", bus.in_ready);
        end
        m_rdy = 1;
    endtask

    task automatic test_directed();
        job_t        jt[7];
        logic [32:0] ex[7];
        logic [15:0] c = 0;
        do_reset();
        jt[0] = mk(0, 'h13, 1, 0, 0, 0, 5);          ex[0] = 33'h0_0050_0093;
        jt[1] = mk(1, 'h23, 0, 1, 2, 2, 8);          ex[1] = 33'h0_0020_A423;
        jt[2] = mk(2, 'h63, 0, 0, 0, 0, -4);         ex[2] = 33'h0_FE00_0EE3;
        jt[3] = mk(3, 'h37, 5, 0, 0, 0, 'h12345000); ex[3] = 33'h0_1234_52B7;
        jt[4] = mk(4, 'h6F, 1, 0, 0, 0, 2048);       ex[4] = 33'h0_0010_00EF;
        jt[5] = mk(0, 'h13, 1, 0, 0, 0, 2048);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        ex[5] = 33'h1_0000_0000;
`else
        ex[5] = 33'h0_8000_0093;
`endif
        jt[6] = mk(5, 'h13, 1, 2, 3, 0, 0);          ex[6] = 33'h1_0000_0000;
        for (int i = 0; i < 7; i++) begin
            drive(1, jt[i], 0);
            checks++;
            if ({bus.out_valid, bus.out_err, bus.out_instr} !== {1'b1, ex[i]}) begin
                failures++;
                $display("FAIL directed_%0d: valid=%b err=%b instr=%h, required valid=1 err=%b instr=%h",
                         i, bus.out_valid, bus.out_err, bus.out_instr, ex[i][32], ex[i][31:0]);
            end
            drive(0, jt[i], 1);
            if (!ex[i][32]) c++;
            checks++;
            if (bus.out_valid !== 1'b0 || enc_count !== c) begin
                failures++;
                $display("FAIL directed_pop_%0d: valid=%b enc_count=%0d, required valid=0 enc_count=%0d",
                         i, bus.out_valid, enc_count, c);
            end
        end
    endtask

    task automatic test_back_to_back();
        job_t        a = rand_job();
        job_t        b = rand_job();
        job_t        cj = rand_job();
        job_t        idle = mk(0, 0, 0, 0, 0, 0, 0);
        logic [32:0] ea = ref_enc(a);
        logic [32:0] eb = ref_enc(b);
        logic [32:0] ec = ref_enc(cj);
        do_reset();
        drive(1, a, 0);
        checks++;
        if (bus.in_ready !== 1'b1 || {bus.out_err, bus.out_instr} !== ea) begin
            failures++;
            $display("FAIL b2b_first: in_ready=%b out=%h, required in_ready=1 out=%h",
                     bus.in_ready, {bus.out_err, bus.out_instr}, ea);
        end
        drive(1, b, 0);
        checks++;
        if (bus.in_ready !== 1'b0 || {bus.out_err, bus.out_instr} !== ea) begin
            failures++;
            $display("FAIL b2b_full: in_ready=%b out=%h, required in_ready=0 out=%h",
                     bus.in_ready, {bus.out_err, bus.out_instr}, ea);
        end
        drive(1, cj, 0);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || {bus.out_err, bus.out_instr} !== ea) begin
            failures++;
            $display("FAIL b2b_hold: in_ready=%b valid=%b out=%h, required in_ready=0 valid=1 out=%h",
                     bus.in_ready, bus.out_valid, {bus.out_err, bus.out_instr}, ea);
        end
        drive(1, cj, 1);
        checks++;
        if (bus.in_ready !== 1'b1 || {bus.out_err, bus.out_instr} !== eb) begin
            failures++;
            $display("FAIL b2b_pop1: in_ready=%b out=%h, required in_ready=1 out=%h",
                     bus.in_ready, {bus.out_err, bus.out_instr}, eb);
        end
        drive(1, cj, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_err, bus.out_instr} !== ec) begin
            failures++;
            $display("FAIL b2b_third: valid=%b out=%h, required valid=1 out=%h",
                     bus.out_valid, {bus.out_err, bus.out_instr}, ec);
        end
        drive(0, idle, 1);
        checks++;
        if (bus.out_valid !== 1'b0 || enc_count !== m_cnt) begin
            failures++;
            $display("FAIL b2b_drain: valid=%b enc_count=%0d, required valid=0 enc_count=%0d",
                     bus.out_valid, enc_count, m_cnt);
        end
    endtask

    task automatic test_random();
        logic [32:0] exp;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 9) < 7, rand_job(), $urandom_range(0, 9) < 6);
            exp = (m_q.size() != 0) ? m_q[0] : 33'd0;
            checks++;
            if (bus.out_valid !== (m_q.size() != 0) || {bus.out_err, bus.out_instr} !== exp
                || bus.in_ready !== m_rdy || enc_count !== m_cnt) begin
                failures++;
                $display("FAIL random_%0d: valid=%b out=%h rdy=%b cnt=%0d, required valid=%b out=%h rdy=%b cnt=%0d",
                         n, bus.out_valid, {bus.out_err, bus.out_instr}, bus.in_ready, enc_count,
                         m_q.size() != 0, exp, m_rdy, m_cnt);
            end
        end
    endtask

    task automatic test_reset_midstream();
        job_t j = mk(0, 'h13, 1, 0, 0, 0, 5);
        do_reset();
        drive(1, j, 0);
        drive(1, j, 1);
        drive(1, j, 0);
        checks++;
        if (enc_count !== 16'd1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_setup: enc_count=%0d in_ready=%b, required 1 and 0", enc_count, bus.in_ready);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_err, bus.out_instr, bus.in_ready, enc_count} !== 51'd0) begin
            failures++;
            $display("FAIL mid_reset: valid=%b err=%b instr=%h in_ready=%b cnt=%0d, required all 0",
                     bus.out_valid, bus.out_err, bus.out_instr, bus.in_ready, enc_count);
        end
        bus.in_valid = 0; bus.out_ready = 1;
        m_q.delete(); m_cnt = 0; m_rdy = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        m_rdy = 1;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (bus.out_valid !== 1'b0 || enc_count !== 16'd0 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL mid_release_%0d: valid=%b cnt=%0d in_ready=%b, required 0 0 1",
                         n, bus.out_valid, enc_count, bus.in_ready);
            end
            drive(0, j, 1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter COUNT_W, default 16: width of the encoded-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  request carries a valid encode job.
REQ-005 in_ready  output  1  encoder can accept a job this cycle.
REQ-006 fmt  input  3  format: 0=I, 1=S, 2=B, 3=U, 4=J; 5-7 illegal.
REQ-007 opcode  input  7  placed verbatim in instruction bits [6:0].
REQ-008 rd, rs1, rs2  input  5 each  register fields.
REQ-009 funct3  input  3  placed in bits [14:12] for I/S/B.
REQ-010 imm  input  32  signed immediate, byte offset for B/J, full value for U.
REQ-011 out_valid  output  1  head entry is valid.
REQ-012 out_ready  input  1  consumer accepts head entry.
REQ-013 out_instr  output  32  encoded instruction of the head entry; 0 when empty.
REQ-014 out_err  output  1  head entry failed encoding; out_instr is 0 for such entries.
REQ-015 enc_count  output  COUNT_W  count of error-free instructions popped.

Function
REQ-016 Jobs are encoded combinationally at input and written into a 2-entry FIFO on in_valid && in_ready.
REQ-017 Latency: a job accepted in cycle N appears at the output with out_valid=1 in cycle N+1 if the FIFO was empty.
REQ-018 in_ready is registered: 1 when fewer than 2 entries are held; no same-cycle pass-through when full.
REQ-019 Pop on out_valid && out_ready; simultaneous push and pop with 1 entry leaves occupancy at 1, order preserved.
REQ-020 out_valid, out_instr and out_err hold stable while out_valid && !out_ready.
REQ-021 I: {imm[11:0], rs1, funct3, rd, opcode}.
REQ-022 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-023 B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-024 U: {imm[31:12], rd, opcode}; J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-025 Illegal fmt: entry stored with out_err=1, out_instr=0.
REQ-026 enc_count increments by 1 on each pop with out_err=0, wraps from 2^COUNT_W-1 to 0.
REQ-027 Empty FIFO: out_valid=0, out_err=0, out_instr=0; out_ready ignored.

Reset
REQ-028 Asserting rst clears both FIFO entries and pointers immediately, including jobs mid-stream.
REQ-029 While rst is asserted: out_valid=0, out_err=0, out_instr=0, enc_count=0, in_ready=0.
REQ-030 in_ready rises on the first clock edge after rst deasserts.

Configuration
REQ-031 Macro INSTR_ENCODER_RANGE_CHECK_EN defined: unrepresentable immediates set out_err=1 and out_instr=0 (I/S outside [-2048,2047]; B odd or outside [-4096,4094]; J odd or outside [-1048576,1048574]; U with imm[11:0] != 0).
REQ-032 Macro undefined: no range check; immediates silently truncated per REQ-021..024; out_err set only for illegal fmt.

Verification
REQ-033 I fmt=0, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> next cycle out_instr=0x00500093, out_err=0; after pop enc_count=1.
REQ-034 S opcode=0x23, rs1=1, rs2=2, funct3=2, imm=8 -> 0x0020A423; B opcode=0x63, all regs 0, imm=-4 -> 0xFE000EE3.
REQ-035 U opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7; J opcode=0x6F, rd=1, imm=2048 -> 0x001000EF.
REQ-036 I imm=2048: with macro -> out_err=1, out_instr=0, enc_count unchanged; without macro -> out_instr=0x80000093, out_err=0.
REQ-037 out_ready=0, 3 back-to-back jobs -> 2 accepted, in_ready=0 from the cycle after the second push; release out_ready -> outputs in order, third job accepted after the first pop.
REQ-038 rst pulse with 2 entries held -> out_valid=0 and enc_count=0 immediately; no stale entry emitted after release.
